// File: rtl/hdmi_pll_reconfig_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_pll_reconfig_ctrl
// Purpose  : Reprograms the HDMI pixel/serial PLL through the Altera PLL
//            reconfiguration Avalon-MM management port when a new video mode
//            is requested. It then waits for a stable lock, retries with a
//            PLL reset on lock timeout, and holds the pixel domain in reset
//            until the new clock is usable.
// Ports    : clk, reset_n (async active-low)
//            mode_sel[1:0], mode_req      - mode request from mode register
//            busy, done, error            - status (all registered)
//            mgmt_address/writedata/write - reconfig write master
//            mgmt_waitrequest             - reconfig stall
//            pll_rst, pll_locked          - PLL control / async lock input
//            pixel_reset_n                - pixel-domain reset, active low
// Config   : HDMI_PLL_LOCK_MONITOR_EN - when defined, a lock loss while idle
//            re-enters the lock wait and resets the pixel domain.
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_pll_reconfig_ctrl #(
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int RST_CYCLES    = 16,
  parameter int MAX_RETRY     = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  mode_sel,
  input  logic        mode_req,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        mgmt_write,
  input  logic        mgmt_waitrequest,
  output logic        pll_rst,
  input  logic        pll_locked,
  output logic        pixel_reset_n
);

  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int YW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR        = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_STABLE    = 3'd3,
    S_PRST      = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

  // Counter word: bypass-only when d == 1, otherwise low/high halves + odd.
  function automatic logic [17:0] enc_div(input logic [7:0] d);
    logic [17:0] r;
    r = '0;
    if (d == 8'd1) begin
      r[16] = 1'b1;
    end else begin
      r[7:0]  = {1'b0, d[7:1]};
      r[15:8] = {1'b0, d[7:1]} + {7'd0, d[0]};
      r[17]   = d[0];
    end
    return r;
  endfunction

  // Returns {M, N, C0, C1}; mode 3 aliases mode 0.
  function automatic logic [31:0] mode_rom(input logic [1:0] m);
    case (m)
      2'd1:    return {8'd60, 8'd11, 8'd30, 8'd6};
      2'd2:    return {8'd5,  8'd1,  8'd5,  8'd1};
      default: return {8'd5,  8'd1,  8'd10, 8'd2};
    endcase
  endfunction

  // Write sequence entry: {address, writedata}.
  function automatic logic [37:0] wr_entry(input logic [2:0] i, input logic [31:0] rom);
    case (i)
      3'd0:    return {6'd0, 32'd0};
      3'd1:    return {6'd3, 14'd0, enc_div(rom[23:16])};
      3'd2:    return {6'd4, 14'd0, enc_div(rom[31:24])};
      3'd3:    return {6'd5, 9'd0, 5'd0, enc_div(rom[15:8])};
      3'd4:    return {6'd5, 9'd0, 5'd1, enc_div(rom[7:0])};
      default: return {6'd2, 32'd0};
    endcase
  endfunction

  state_t        state, state_n;
  logic [1:0]    mode, mode_n;
  logic [2:0]    widx, widx_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [SW-1:0] scnt, scnt_n;
  logic [RW-1:0] rcnt, rcnt_n;
  logic [YW-1:0] retry, retry_n;
  logic          busy_n, done_n, error_n, write_n, pll_rst_n, pix_n;
  logic [5:0]    addr_n;
  logic [31:0]   wdata_n;
  logic          lock_meta, lock_sync;
  logic [37:0]   entry;
  logic [TW-1:0] tcnt_inc;
  logic [SW-1:0] scnt_inc;
  logic [RW-1:0] rcnt_inc;
`ifdef HDMI_PLL_LOCK_MONITOR_EN
  logic          lock_d;
`endif

  assign entry    = wr_entry(widx, mode_rom(mode));
  assign tcnt_inc = tcnt + TW'(1);
  assign scnt_inc = scnt + SW'(1);
  assign rcnt_inc = rcnt + RW'(1);

  // Reset state is the lock wait: boot behaves like a mode-0 request whose
  // writes were already applied by the PLL's power-up configuration.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_WAIT_LOCK;
      mode           <= 2'd0;
      widx           <= 3'd0;
      tcnt           <= '0;
      scnt           <= '0;
      rcnt           <= '0;
      retry          <= '0;
      busy           <= 1'b1;
      done           <= 1'b0;
      error          <= 1'b0;
      mgmt_address   <= 6'd0;
      mgmt_writedata <= 32'd0;
      mgmt_write     <= 1'b0;
      pll_rst        <= 1'b0;
      pixel_reset_n  <= 1'b0;
      lock_meta      <= 1'b0;
      lock_sync      <= 1'b0;
`ifdef HDMI_PLL_LOCK_MONITOR_EN
      lock_d         <= 1'b0;
`endif
    end else begin
      state          <= state_n;
      mode           <= mode_n;
      widx           <= widx_n;
      tcnt           <= tcnt_n;
      scnt           <= scnt_n;
      rcnt           <= rcnt_n;
      retry          <= retry_n;
      busy           <= busy_n;
      done           <= done_n;
      error          <= error_n;
      mgmt_address   <= addr_n;
      mgmt_writedata <= wdata_n;
      mgmt_write     <= write_n;
      pll_rst        <= pll_rst_n;
      pixel_reset_n  <= pix_n;
      lock_meta      <= pll_locked;
      lock_sync      <= lock_meta;
`ifdef HDMI_PLL_LOCK_MONITOR_EN
      lock_d         <= lock_sync;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    mode_n    = mode;
    widx_n    = widx;
    tcnt_n    = tcnt;
    scnt_n    = scnt;
    rcnt_n    = rcnt;
    retry_n   = retry;
    busy_n    = busy;
    done_n    = 1'b0;
    error_n   = error;
    addr_n    = mgmt_address;
    wdata_n   = mgmt_writedata;
    write_n   = mgmt_write;
    pll_rst_n = pll_rst;
    pix_n     = pixel_reset_n;

    case (state)
      S_IDLE: begin
        if (mode_req) begin
          mode_n  = mode_sel;
          widx_n  = 3'd0;
          busy_n  = 1'b1;
          error_n = 1'b0;
          pix_n   = 1'b0;
          state_n = S_WR;
        end
`ifdef HDMI_PLL_LOCK_MONITOR_EN
        // Only a falling edge counts, so an errored PLL left unlocked in
        // idle does not loop through the retry path forever.
        else if (lock_d && !lock_sync) begin
          busy_n  = 1'b1;
          pix_n   = 1'b0;
          tcnt_n  = '0;
          retry_n = '0;
          state_n = S_WAIT_LOCK;
        end
`endif
      end

      S_WR: begin
        // Strobe low for one cycle between writes: raise it with fresh
        // address/data, hold everything until the slave stops stalling.
        if (!mgmt_write) begin
          write_n = 1'b1;
          addr_n  = entry[37:32];
          wdata_n = entry[31:0];
        end else if (!mgmt_waitrequest) begin
          write_n = 1'b0;
          if (widx == 3'd5) begin
            tcnt_n  = '0;
            retry_n = '0;
            state_n = S_WAIT_LOCK;
          end else begin
            widx_n = widx + 3'd1;
          end
        end
      end

      S_WAIT_LOCK: begin
        if (lock_sync) begin
          scnt_n  = '0;
          state_n = S_STABLE;
        end else if (tcnt_inc == TW'(LOCK_TIMEOUT)) begin
          tcnt_n = '0;
          if (retry == YW'(MAX_RETRY)) begin
            state_n = S_ERROR;
          end else begin
            retry_n   = retry + YW'(1);
            rcnt_n    = '0;
            pll_rst_n = 1'b1;
            state_n   = S_PRST;
          end
        end else begin
          tcnt_n = tcnt_inc;
        end
      end

      S_STABLE: begin
        if (!lock_sync) begin
          tcnt_n  = '0;
          state_n = S_WAIT_LOCK;
        end else if (scnt_inc == SW'(STABLE_CYCLES)) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          pix_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          scnt_n = scnt_inc;
        end
      end

      S_PRST: begin
        if (rcnt_inc == RW'(RST_CYCLES)) begin
          pll_rst_n = 1'b0;
          tcnt_n    = '0;
          state_n   = S_WAIT_LOCK;
        end else begin
          rcnt_n = rcnt_inc;
        end
      end

      S_ERROR: begin
        error_n = 1'b1;
        busy_n  = 1'b0;
        pix_n   = 1'b0;
        state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_hdmi_pll_reconfig_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdmi_pll_reconfig_ctrl
// Purpose  : Directed self-checking bench for hdmi_pll_reconfig_ctrl with
//            shortened timing parameters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdmi_pll_reconfig_ctrl;

  localparam int LT = 200;
  localparam int SC = 16;
  localparam int RC = 4;
  localparam int MR = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  mode_sel;
  logic        mode_req;
  logic        busy, done, error;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        mgmt_write;
  logic        mgmt_waitrequest;
  logic        pll_rst;
  logic        pll_locked;
  logic        pixel_reset_n;

  always #5 clk = ~clk;

  hdmi_pll_reconfig_ctrl #(
    .LOCK_TIMEOUT (LT),
    .STABLE_CYCLES(SC),
    .RST_CYCLES   (RC),
    .MAX_RETRY    (MR)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .mode_sel        (mode_sel),
    .mode_req        (mode_req),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .mgmt_address    (mgmt_address),
    .mgmt_writedata  (mgmt_writedata),
    .mgmt_write      (mgmt_write),
    .mgmt_waitrequest(mgmt_waitrequest),
    .pll_rst         (pll_rst),
    .pll_locked      (pll_locked),
    .pixel_reset_n   (pixel_reset_n)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Bus and reset-pulse observers.
  int          cyc = 0;
  int          wr_cycles = 0;
  int          rst_run = 0;
  int          rst_pulses = 0;
  int          rst_badw = 0;
  int          done_cnt = 0;
  logic [37:0] acc_q[$];
  int          acc_cyc[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mgmt_write) wr_cycles <= wr_cycles + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (mgmt_write && !mgmt_waitrequest) begin
      acc_q.push_back({mgmt_address, mgmt_writedata});
      acc_cyc.push_back(cyc);
    end
    if (pll_rst) begin
      rst_run <= rst_run + 1;
    end else if (rst_run != 0) begin
      rst_pulses <= rst_pulses + 1;
      if (rst_run != RC) rst_badw <= rst_badw + 1;
      rst_run <= 0;
    end
  end

  // Hand-encoded expected writes {addr, data}.
  // Mode 1: N=11 -> low 5, high 6, odd bit17; M=60; C0=30; C1=6 with index 1.
  logic [37:0] exp1 [6] = '{
    {6'd0, 32'h0000_0000}, {6'd3, 32'h0002_0605}, {6'd4, 32'h0000_1E1E},
    {6'd5, 32'h0000_0F0F}, {6'd5, 32'h0004_0303}, {6'd2, 32'h0000_0000}};
  // Mode 2: N=1 bypass; M=5 -> low 2, high 3, odd; C0=5; C1=1 bypass index 1.
  logic [37:0] exp2 [6] = '{
    {6'd0, 32'h0000_0000}, {6'd3, 32'h0001_0000}, {6'd4, 32'h0002_0302},
    {6'd5, 32'h0002_0302}, {6'd5, 32'h0005_0000}, {6'd2, 32'h0000_0000}};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns the tick index (1-based) on which done is first seen, or -1.
  task automatic wait_done(input int bound, output int k);
    k = -1;
    for (int i = 1; i <= bound; i++) begin
      tick();
      if (done === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int base;
    int rp0;
    int dc0;
    logic [5:0]  a0;
    logic [31:0] d0;
    logic        stable_ok;

    reset_n = 1'b0; mode_sel = 2'd0; mode_req = 1'b0;
    mgmt_waitrequest = 1'b0; pll_locked = 1'b0;
    repeat (3) tick();

    // Reset values
    chk("rst_busy",  busy, 1);
    chk("rst_done",  done, 0);
    chk("rst_error", error, 0);
    chk("rst_pix",   pixel_reset_n, 0);
    chk("rst_write", mgmt_write, 0);
    chk("rst_addr",  mgmt_address, 0);
    chk("rst_data",  mgmt_writedata, 0);
    chk("rst_pllrst", pll_rst, 0);

    // Boot: lock arrives 100 cycles after release, no writes expected
    reset_n = 1'b1;
    repeat (100) tick();
    chk("boot_busy_waiting", busy, 1);
    pll_locked = 1'b1;
    wait_done(SC + 20, k);
    chk("boot_done_latency", k, SC + 3);
    chk("boot_pix_with_done", pixel_reset_n, 1);
    chk("boot_busy_clear", busy, 0);
    chk("boot_no_writes", wr_cycles, 0);
    tick();
    chk("boot_done_pulse", done, 0);

    // Mode 1, no stalls; a second request mid-sequence must be ignored
    base = acc_q.size();
    mode_sel = 2'd1; mode_req = 1'b1;
    tick();
    mode_req = 1'b0;
    chk("m1_busy", busy, 1);
    chk("m1_pix_low", pixel_reset_n, 0);
    repeat (3) tick();
    mode_sel = 2'd2; mode_req = 1'b1;
    tick();
    mode_req = 1'b0;
    wait_done(100, k);
    chk("m1_done_seen", (k > 0), 1);
    chk("m1_write_count", acc_q.size() - base, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("m1_wr%0d", i), acc_q[base + i], exp1[i]);
    chk("m1_write_spacing", acc_cyc[base + 5] - acc_cyc[base], 10);

    // Mode 2 with 5 stall cycles on every write
    mgmt_waitrequest = 1'b1;
    mode_sel = 2'd2; mode_req = 1'b1;
    tick();
    mode_req = 1'b0;
    stable_ok = 1'b1;
    for (int w = 0; w < 6; w++) begin
      for (int t = 0; t < 10 && !mgmt_write; t++) tick();
      a0 = mgmt_address;
      d0 = mgmt_writedata;
      chk($sformatf("m2_wr%0d", w), {mgmt_write, a0, d0}, {1'b1, exp2[w]});
      repeat (5) begin
        tick();
        if (!(mgmt_write === 1'b1 && mgmt_address === a0 && mgmt_writedata === d0))
          stable_ok = 1'b0;
      end
      mgmt_waitrequest = 1'b0;
      tick();
      mgmt_waitrequest = 1'b1;
    end
    mgmt_waitrequest = 1'b0;
    chk("m2_stall_stable", stable_ok, 1);
    wait_done(100, k);
    chk("m2_done_seen", (k > 0), 1);

    // Reset mid-sequence aborts immediately
    mode_sel = 2'd1; mode_req = 1'b1;
    tick();
    mode_req = 1'b0;
    repeat (3) tick();
    chk("abort_pre_write", mgmt_write, 1);
    reset_n = 1'b0;
    #2;
    chk("abort_write", mgmt_write, 0);
    chk("abort_addr",  mgmt_address, 0);
    chk("abort_busy",  busy, 1);
    chk("abort_pix",   pixel_reset_n, 0);
    tick();
    reset_n = 1'b1;
    wait_done(SC + 20, k);
    chk("abort_reboot_done", (k > 0), 1);

    // Lock never arrives: MR reset pulses of RC cycles, then error
    pll_locked = 1'b0;
    mode_sel = 2'd0; mode_req = 1'b1;
    tick();
    mode_req = 1'b0;
    rp0 = rst_pulses;
    for (int t = 0; t < 3000 && !error; t++) tick();
    chk("nolock_error", error, 1);
    chk("nolock_busy", busy, 0);
    chk("nolock_pix", pixel_reset_n, 0);
    chk("nolock_pulses", rst_pulses - rp0, MR);
    chk("nolock_pulse_width_bad", rst_badw, 0);

    // Lock drop during STABLE restarts the stable count
    mode_sel = 2'd1; mode_req = 1'b1;
    tick();
    mode_req = 1'b0;
    chk("drop_error_cleared", error, 0);
    repeat (20) tick();
    chk("drop_busy_waiting", busy, 1);
    dc0 = done_cnt;
    pll_locked = 1'b1;
    repeat (10) tick();
    pll_locked = 1'b0;
    repeat (3) tick();
    pll_locked = 1'b1;
    wait_done(SC + 20, k);
    chk("drop_done_latency", k, SC + 3);
    chk("drop_no_early_done", done_cnt - dc0, 0);

    // Lock loss while idle
    tick();
    pll_locked = 1'b0;
    repeat (3) tick();
`ifdef HDMI_PLL_LOCK_MONITOR_EN
    chk("idle_loss_pix", pixel_reset_n, 0);
    chk("idle_loss_busy", busy, 1);
`else
    chk("idle_loss_pix", pixel_reset_n, 1);
    chk("idle_loss_busy", busy, 0);
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
